// File: rtl/vscpu_run_ctrl_if.sv
// Host access port of the VSCPU run controller.
// Master drives requests, slave answers with ready/rvalid/rdata.
interface vscpu_run_ctrl_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic              h_valid;
   logic              h_we;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_wdata;
   logic              h_ready;
   logic              h_rvalid;
   logic [DATA_W-1:0] h_rdata;

   modport master (
      output h_valid, h_we, h_addr, h_wdata,
      input  h_ready, h_rvalid, h_rdata
   );

   modport slave (
      input  h_valid, h_we, h_addr, h_wdata,
      output h_ready, h_rvalid, h_rdata
   );
endinterface

// File: rtl/vscpu_run_ctrl.sv
// Run controller and RAM port owner for VSCPU + blram.
// Host owns RAM outside RUN; CPU owns it during a bounded run.
module vscpu_run_ctrl #(
   parameter int              ADDR_W    = 14,
   parameter int              DATA_W    = 32,
   parameter logic [ADDR_W-1:0] HALT_ADDR = 14'h3FFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [31:0]       run_cycles,
   vscpu_run_ctrl_if.slave   host,
   output logic              cpu_rst,
   input  logic              cpu_wrEn,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy,
   output logic              done,
   output logic              halted,
   output logic              timeout,
   output logic [31:0]       cycles_run
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] cyc_q, cyc_d;
   logic        halted_q, halted_d;
   logic        tmo_q, tmo_d;
   logic        rvalid_q, rvalid_d;

   logic        run;
   logic        h_acc;
   logic        halt_wr;

   // RAM ownership and CPU reset decode purely from the state register
   always_comb begin
      run       = (state_q == S_RUN);
      h_acc     = host.h_valid & host.h_ready;
      halt_wr   = cpu_wrEn & (cpu_addr == HALT_ADDR);
      cpu_rst   = ~run;
      host.h_ready = ~run & ~start;
      if (run) begin
         ram_we   = cpu_wrEn;
         ram_addr = cpu_addr;
         ram_din  = cpu_wdata;
      end else begin
         ram_we   = h_acc & host.h_we;
         ram_addr = host.h_addr;
         ram_din  = host.h_wdata;
      end
   end

   assign host.h_rdata  = ram_dout;
   assign host.h_rvalid = rvalid_q;
   assign cpu_rdata     = ram_dout;
   assign busy          = run;
   assign done          = (state_q == S_DONE);
   assign halted        = halted_q;
   assign timeout       = tmo_q;
   assign cycles_run    = cyc_q;

   // Run sequencing: start/abort/halt/budget with abort > halt > timeout
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      halted_d = halted_q;
      tmo_d    = tmo_q;
      rvalid_d = h_acc & ~host.h_we;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               cyc_d    = '0;
               halted_d = 1'b0;
               tmo_d    = 1'b0;
               cnt_d    = run_cycles;
               if (run_cycles == '0) begin
                  state_d = S_DONE;
                  tmo_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            cyc_d = cyc_q + 32'd1;
            cnt_d = cnt_q - 32'd1;
            if (abort) begin
               state_d  = S_DONE;
               halted_d = 1'b0;
               tmo_d    = 1'b0;
            end else if (halt_wr) begin
               state_d  = S_DONE;
               halted_d = 1'b1;
            end else if (cnt_q == 32'd1) begin
               state_d = S_DONE;
               tmo_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         cyc_q    <= '0;
         halted_q <= 1'b0;
         tmo_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         halted_q <= halted_d;
         tmo_q    <= tmo_d;
         rvalid_q <= rvalid_d;
      end
   end

endmodule

// File: tb/tb_vscpu_run_ctrl.sv
// Directed bench for vscpu_run_ctrl with a behavioural blram
// and a scripted CPU driving the memory port.
module tb_vscpu_run_ctrl;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam logic [AW-1:0] HADDR = 14'h3FFF;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [31:0]   run_cycles;
   logic          cpu_rst;
   logic          cpu_wrEn;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          busy, done, halted, timeout;
   logic [31:0]   cycles_run;

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   vscpu_run_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();

   vscpu_run_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .HALT_ADDR(HADDR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .run_cycles (run_cycles),
      .host       (hif.slave),
      .cpu_rst    (cpu_rst),
      .cpu_wrEn   (cpu_wrEn),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout),
      .busy       (busy),
      .done       (done),
      .halted     (halted),
      .timeout    (timeout),
      .cycles_run (cycles_run)
   );

   always #5 clk = ~clk;

   // Behavioural blram: write plus registered read-first output
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_wr(input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      hif.h_valid = 1'b1;
      hif.h_we    = 1'b1;
      hif.h_addr  = a;
      hif.h_wdata = d;
      tick();
      hif.h_valid = 1'b0;
      hif.h_we    = 1'b0;
   endtask

   task automatic host_rd(input string tag,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
      hif.h_valid = 1'b1;
      hif.h_we    = 1'b0;
      hif.h_addr  = a;
      tick();
      hif.h_valid = 1'b0;
      check({tag, "_rv"}, 32'(hif.h_rvalid), 32'd1);
      check(tag, hif.h_rdata, exp);
   endtask

   task automatic do_start(input logic [31:0] b);
      start      = 1'b1;
      run_cycles = b;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      run_cycles = '0;
      cpu_wrEn = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      hif.h_valid = 1'b0;
      hif.h_we = 1'b0;
      hif.h_addr = '0;
      hif.h_wdata = '0;
      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
      tick();
      tick();
      check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_cycles", cycles_run, 32'd0);
      check("rst_rvalid", 32'(hif.h_rvalid), 32'd0);
      check("rst_ready", 32'(hif.h_ready), 32'd1);
      rst = 1'b0;
      tick();

      // host writes and back-to-back reads
      host_wr(14'd5, 32'hDEADBEEF);
      host_wr(14'd6, 32'h12345678);
      host_wr(14'd9, 32'h00000099);
      hif.h_valid = 1'b1;
      hif.h_we = 1'b0;
      hif.h_addr = 14'd5;
      tick();
      check("b2b_rv0", 32'(hif.h_rvalid), 32'd1);
      check("b2b_rd0", hif.h_rdata, 32'hDEADBEEF);
      hif.h_addr = 14'd6;
      tick();
      hif.h_valid = 1'b0;
      check("b2b_rv1", 32'(hif.h_rvalid), 32'd1);
      check("b2b_rd1", hif.h_rdata, 32'h12345678);
      tick();
      check("b2b_rv_end", 32'(hif.h_rvalid), 32'd0);

      // halt run: CPU writes 7 to mailbox in RUN cycle 5
      start = 1'b1;
      run_cycles = 32'd1000;
      #1;
      check("ready_at_start", 32'(hif.h_ready), 32'd0);
      tick();
      start = 1'b0;
      check("run_busy", 32'(busy), 32'd1);
      check("run_cpu_rst", 32'(cpu_rst), 32'd0);
      check("run_ready", 32'(hif.h_ready), 32'd0);
      for (int i = 1; i < 5; i++) tick();
      cpu_wrEn = 1'b1;
      cpu_addr = HADDR;
      cpu_wdata = 32'd7;
      tick();
      cpu_wrEn = 1'b0;
      cpu_addr = '0;
      check("halt_done", 32'(done), 32'd1);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_timeout", 32'(timeout), 32'd0);
      check("halt_cycles", cycles_run, 32'd5);
      check("halt_cpu_rst", 32'(cpu_rst), 32'd1);
      host_rd("halt_mbox", HADDR, 32'd7);

      // budget exhaustion after 50 RUN cycles
      do_start(32'd50);
      n = 0;
      while (busy && n < 200) begin
         n++;
         tick();
      end
      check("tmo_run_len", 32'(n), 32'd50);
      check("tmo_done", 32'(done), 32'd1);
      check("tmo_timeout", 32'(timeout), 32'd1);
      check("tmo_halted", 32'(halted), 32'd0);
      check("tmo_cycles", cycles_run, 32'd50);

      // zero budget: straight to DONE, CPU never released
      do_start(32'd0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_timeout", 32'(timeout), 32'd1);
      check("zero_cpu_rst", 32'(cpu_rst), 32'd1);
      check("zero_cycles", cycles_run, 32'd0);

      // host write ignored in RUN, abort in RUN cycle 10
      do_start(32'd100);
      cpu_addr = 14'd20;
      hif.h_valid = 1'b1;
      hif.h_we = 1'b1;
      hif.h_addr = 14'd9;
      hif.h_wdata = 32'h0000AAAA;
      #1;
      check("blk_ready", 32'(hif.h_ready), 32'd0);
      for (int i = 1; i < 10; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      hif.h_valid = 1'b0;
      hif.h_we = 1'b0;
      cpu_addr = '0;
      check("abt_done", 32'(done), 32'd1);
      check("abt_halted", 32'(halted), 32'd0);
      check("abt_timeout", 32'(timeout), 32'd0);
      check("abt_cycles", cycles_run, 32'd10);
      host_rd("blk_addr9", 14'd9, 32'h00000099);

      // asynchronous reset in the middle of a run
      do_start(32'd100);
      tick();
      tick();
      check("mid_busy_pre", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_cpu_rst", 32'(cpu_rst), 32'd1);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_cycles", cycles_run, 32'd0);
      check("mid_ready", 32'(hif.h_ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
